intercal_alu_seq: RTL and testbench
===================================

# intercal_alu_seq

Parametrised, sequential INTERCAL ALU: the next generation of the 16/32-bit TinyTapeout INTERCAL ALU. It generalises operand width and adds a byte-serial operand load and result read port, a start/busy/done handshake, and an iterative (bit-serial) select engine. It sits behind an 8-bit pin bus in the TT wrapper and executes mingle, select and the three unary operators.

## Interface
- WIDTH, 16, operand/result width in bits; legal values 16, 32, 64 (multiple of 8, even)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  shift wr_data into the operand selected by wr_sel
- wr_sel  in  1  0 = operand A, 1 = operand B
- wr_data  in  8  operand byte, loaded LSB byte first
- start  in  1  begin operation op; sampled only in IDLE
- op  in  3  0 MINGLE, 1 SELECT, 2 UAND, 3 UOR, 4 UXOR, 5–7 illegal
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result valid
- err  out  1  last op was illegal; held until next start
- rd_en  in  1  rotate result right by 8
- rd_data  out  8  result[7:0], combinational
- res  out  WIDTH  full result register

## Operation
- Operand write (IDLE only): reg <= {wr_data, reg[WIDTH-1:8]}, so after WIDTH/8 writes the first byte is the LSB. wr_en is ignored when busy, or when start is high in the same cycle (start wins).
- States: IDLE -> EXEC on start; EXEC -> DONE when the op completes; DONE -> IDLE unconditionally.
- MINGLE: H = WIDTH/2. res[2i+1] = A[i], res[2i] = B[i] for i < H. Upper halves of A and B are ignored. 1 EXEC cycle.
- SELECT: bits of A at positions where B = 1, packed toward the LSB in ascending order; upper bits are 0. Computed one bit per cycle by index i = 0..WIDTH-1 with pack pointer k: if B[i], then res[k] <= A[i] and k++. Takes WIDTH EXEC cycles. res is cleared on entry to EXEC.
- UAND/UOR/UXOR: res = A op {A[0], A[WIDTH-1:1]}, i.e. each bit combined with its left neighbour and the MSB combined with bit 0. 1 EXEC cycle.
- Illegal op: err <= 1, res <= 0, 1 EXEC cycle. err is cleared on any legal start.
- rd_en (IDLE only): res <= {res[7:0], res[WIDTH-1:8]}. WIDTH/8 reads restore the original value. Ignored when busy or when start is high in the same cycle.
- A and B are unchanged by any operation.

## Timing
- Reset values: state IDLE, A = B = res = 0, busy = done = err = 0, rd_data = 0, internal counters 0.
- Start sampled at edge t:
  - busy = 1 from t+1.
  - Single-cycle ops: EXEC during cycle t+1, DONE (done = 1, busy = 1) during t+2, IDLE with busy = 0 at t+3.
  - SELECT: EXEC during t+1..t+WIDTH, DONE at t+WIDTH+1.
- res is final when done is high.
- start while busy is ignored; no queuing.
- Reset mid-operation: immediate return to reset values, including a partial select result. No done pulse is issued.
- A start in the DONE cycle is ignored. The earliest back-to-back start is in the IDLE cycle that follows.

## Structure
- Package intercal_alu_pkg: op_e enum (OP_MINGLE = 0 … OP_UXOR = 4), state_e enum (IDLE, EXEC, DONE), constant BYTE_W = 8.
- Sub-module intercal_select_seq: holds the bit index and pack pointer. Ports: clk, rst, clear, step, a, b, res, last. Mingle, unary ops, operand load and readout stay in the top module.
- Index/pointer width is $clog2(WIDTH)+1.

## Test plan
- WIDTH = 16. Load A = 0x00FF, B = 0x0000, MINGLE -> done at t+2, res = 0xAAAA; two rd_en reads give 0xAA, 0xAA, and res returns to 0xAAAA.
- SELECT A = 0x1234, B = 0xFF00 -> busy for cycles t+1..t+17, done at t+17, res = 0x0012. Also A = 0xFFFF, B = 0x0F0F -> 0x00FF.
- Unary ops: UAND A = 0x8001 -> 0x8000; UOR A = 0x0001 -> 0x8001; UXOR A = 0x0003 -> 0x8002.
- op = 5 -> err = 1, res = 0, done at t+2. A following legal op clears err.
- Assert rst at cycle t+5 of a SELECT -> busy = 0, res = 0 immediately, no done. start and wr_en pulses during busy have no effect on A, B or res.
- WIDTH = 32: byte writes 0x78, 0x56, 0x34, 0x12 give A = 0x12345678. SELECT with B = 0xFFFFFFFF -> res = 0x12345678, done at t+33.

Source files
------------

// File: rtl/intercal_alu_pkg.sv
// Shared types and constants for the sequential INTERCAL ALU.
package intercal_alu_pkg;

  typedef enum logic [2:0] {
    OP_MINGLE = 3'd0,
    OP_SELECT = 3'd1,
    OP_UAND   = 3'd2,
    OP_UOR    = 3'd3,
    OP_UXOR   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic logic is_legal_op(input logic [2:0] code);
    return code <= OP_UXOR;
  endfunction

endpackage

// File: rtl/intercal_select_seq.sv
// Bit-serial SELECT engine: walks B one bit per step, packing chosen A bits toward the LSB.
module intercal_select_seq
  import intercal_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             last
);

  localparam int unsigned IW = $clog2(WIDTH) + 1;

  logic [IW-1:0]    idx;
  logic [IW-1:0]    k;
  logic [WIDTH-1:0] acc;

  // res already includes the bit placed by the current step, so the caller can
  // latch the finished value on the same edge that ends the walk.
  always_comb begin
    res = acc;
    if (step && b[idx[IW-2:0]]) begin
      res[k[IW-2:0]] = a[idx[IW-2:0]];
    end
  end

  assign last = step && (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      k   <= '0;
      acc <= '0;
    end else if (clear) begin
      idx <= '0;
      k   <= '0;
      acc <= '0;
    end else if (step) begin
      acc <= res;
      idx <= idx + 1'b1;
      if (b[idx[IW-2:0]]) begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/intercal_alu_seq.sv
// Sequential INTERCAL ALU: byte-serial operand load/readout, start/busy/done handshake.
module intercal_alu_seq
  import intercal_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [7:0]       wr_data,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned H = WIDTH / 2;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             err_q;

  logic [WIDTH-1:0] mingle, rot_a, sel_res;
  logic             sel_clear, sel_step, sel_last;

  assign sel_clear = (state_q == IDLE) && start;
  assign sel_step  = (state_q == EXEC) && (op_q == OP_SELECT);

  intercal_select_seq #(.WIDTH(WIDTH)) u_select (
    .clk   (clk),
    .rst   (rst),
    .clear (sel_clear),
    .step  (sel_step),
    .a     (a_q),
    .b     (b_q),
    .res   (sel_res),
    .last  (sel_last)
  );

  always_comb begin
    mingle = '0;
    for (int unsigned i = 0; i < H; i++) begin
      mingle[2*i+1] = a_q[i];
      mingle[2*i]   = b_q[i];
    end
  end

  assign rot_a = {a_q[0], a_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    if (op_q != OP_SELECT || sel_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            err_q <= !is_legal_op(op);
            if (op == OP_SELECT) res_q <= '0;
          end else begin
            if (wr_en) begin
              if (wr_sel) b_q <= {wr_data, b_q[WIDTH-1:BYTE_W]};
              else        a_q <= {wr_data, a_q[WIDTH-1:BYTE_W]};
            end
            if (rd_en) res_q <= {res_q[BYTE_W-1:0], res_q[WIDTH-1:BYTE_W]};
          end
        end
        EXEC: begin
          case (op_q)
            OP_MINGLE: res_q <= mingle;
            OP_SELECT: res_q <= sel_res;
            OP_UAND:   res_q <= a_q & rot_a;
            OP_UOR:    res_q <= a_q | rot_a;
            OP_UXOR:   res_q <= a_q ^ rot_a;
            default:   res_q <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign res     = res_q;
  assign rd_data = res_q[BYTE_W-1:0];

endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed self-checking bench: 16-bit and 32-bit instances share one input bus.
module tb_intercal_alu_seq;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_sel, start, rd_en;
  logic [7:0]  wr_data;
  logic [2:0]  op;

  logic        busy16, done16, err16, busy32, done32, err32;
  logic [7:0]  rd16, rd32;
  logic [15:0] res16;
  logic [31:0] res32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intercal_alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .op(op), .busy(busy16), .done(done16), .err(err16),
    .rd_en(rd_en), .rd_data(rd16), .res(res16)
  );

  intercal_alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .op(op), .busy(busy32), .done(done32), .err(err32),
    .rd_en(rd_en), .rd_data(rd32), .res(res32)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic done_of(input bit big);
    return big ? done32 : done16;
  endfunction

  function automatic logic busy_of(input bit big);
    return big ? busy32 : busy16;
  endfunction

  task automatic wr_byte(input logic sel, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load16(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 2; i++) wr_byte(1'b0, a[8*i +: 8]);
    for (int i = 0; i < 2; i++) wr_byte(1'b1, b[8*i +: 8]);
  endtask

  task automatic rd_pulse();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle t+1 (start sampled at edge t).
  task automatic start_op(input logic [2:0] o);
    @(negedge clk); start = 1'b1; op = o;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int n0, input int exp_cycles, input string name);
    int n = n0;
    while (!done_of(big) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_cycles));
    chk({name, "_busy_at_done"}, 64'(busy_of(big)), 64'd1);
  endtask

  task automatic run16(input string name, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic ee);
    load16(a, b);
    start_op(o);
    chk({name, "_busy_t1"}, 64'(busy16), 64'd1);
    chk({name, "_done_t1"}, 64'(done16), 64'd0);
    wait_done(1'b0, 1, (o == 3'd1) ? 17 : 2, name);
    chk({name, "_res"}, 64'(res16), 64'(er));
    chk({name, "_err"}, 64'(err16), 64'(ee));
    @(negedge clk);
    chk({name, "_idle_busy"}, 64'(busy16), 64'd0);
    chk({name, "_idle_done"}, 64'(done16), 64'd0);
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{3'd0, 16'h00FF, 16'h0000, 16'hAAAA, 1'b0};
    vecs[1]  = '{3'd0, 16'hAB0F, 16'hCDF0, 16'h55AA, 1'b0};
    vecs[2]  = '{3'd1, 16'h1234, 16'hFF00, 16'h0012, 1'b0};
    vecs[3]  = '{3'd1, 16'hFFFF, 16'h0F0F, 16'h00FF, 1'b0};
    vecs[4]  = '{3'd1, 16'hA5A5, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{3'd1, 16'h8001, 16'h8001, 16'h0003, 1'b0};
    vecs[6]  = '{3'd2, 16'h8001, 16'h0000, 16'h8000, 1'b0};
    vecs[7]  = '{3'd3, 16'h0001, 16'h0000, 16'h8001, 1'b0};
    vecs[8]  = '{3'd4, 16'h0003, 16'h0000, 16'h8002, 1'b0};
    vecs[9]  = '{3'd5, 16'h1234, 16'h5678, 16'h0000, 1'b1};
    vecs[10] = '{3'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[11] = '{3'd7, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    start = 1'b0; op = '0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy16), 64'd0);
    chk("rst_done",  64'(done16), 64'd0);
    chk("rst_err",   64'(err16),  64'd0);
    chk("rst_res",   64'(res16),  64'd0);
    chk("rst_rd",    64'(rd16),   64'd0);
    chk("rst_res32", 64'(res32),  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run16($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);

    // Readout: 0x00FF/0x0000 mingle gives 0xAAAA; two rotations restore it.
    run16("rd_a", 3'd0, 16'h00FF, 16'h0000, 16'hAAAA, 1'b0);
    chk("rd_a_byte0", 64'(rd16), 64'hAA);
    rd_pulse();
    chk("rd_a_byte1", 64'(rd16), 64'hAA);
    rd_pulse();
    chk("rd_a_restore", 64'(res16), 64'hAAAA);

    // Asymmetric value exposes rotation direction.
    run16("rd_b", 3'd0, 16'hAB0F, 16'hCDF0, 16'h55AA, 1'b0);
    chk("rd_b_byte0", 64'(rd16), 64'hAA);
    rd_pulse();
    chk("rd_b_rot1", 64'(res16), 64'hAA55);
    chk("rd_b_byte1", 64'(rd16), 64'h55);
    rd_pulse();
    chk("rd_b_restore", 64'(res16), 64'h55AA);

    // Pulses on start/wr_en/rd_en while busy must not disturb anything.
    load16(16'h1234, 16'hFF00);
    start_op(3'd1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'hFF; start = 1'b1; op = 3'd2; rd_en = 1'b1;
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b1; start = 1'b0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    wait_done(1'b0, 5, 17, "busy_ign");
    chk("busy_ign_res", 64'(res16), 64'h0012);
    start = 1'b1; op = 3'd4;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", 64'(busy16), 64'd0);
    chk("done_start_res", 64'(res16), 64'h0012);
    start_op(3'd1);
    wait_done(1'b0, 1, 17, "ab_kept");
    chk("ab_kept_res", 64'(res16), 64'h0012);
    @(negedge clk);

    // Reset in cycle t+5 of a SELECT: partial result discarded, no done.
    load16(16'h1234, 16'hFFFF);
    start_op(3'd1);
    repeat (4) @(negedge clk);
    chk("mid_partial", 64'(res16), 64'h0004);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy16), 64'd0);
    chk("mid_rst_res",  64'(res16),  64'd0);
    chk("mid_rst_done", 64'(done16), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done16 || busy16) ndone++;
    end
    chk("mid_rst_no_done", 64'(ndone), 64'd0);

    // 32-bit instance: byte order and full-width SELECT.
    wr_byte(1'b0, 8'h78); wr_byte(1'b0, 8'h56); wr_byte(1'b0, 8'h34); wr_byte(1'b0, 8'h12);
    for (int i = 0; i < 4; i++) wr_byte(1'b1, 8'hFF);
    start_op(3'd1);
    chk("w32_busy_t1", 64'(busy32), 64'd1);
    wait_done(1'b1, 1, 33, "w32_sel");
    chk("w32_sel_res", 64'(res32), 64'h12345678);
    chk("w32_err", 64'(err32), 64'd0);
    @(negedge clk);
    chk("w32_rd0", 64'(rd32), 64'h78);
    chk("w32_idle", 64'(busy32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
